// File: rtl/mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : mux_scan
// Desc     : Registered CH:1 channel mux with manual select or timed auto-scan.
//            Optional y_par output when macro MUX_SCAN_PARITY_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mux_scan #(
  parameter int CH    = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH*W-1:0]       din,
  input  logic [$clog2(CH)-1:0] sel,
  input  logic                  mode,
  input  logic                  en,
  output logic [W-1:0]          y,
  output logic [$clog2(CH)-1:0] ch_out,
  output logic                  valid,
  output logic                  wrap
`ifdef MUX_SCAN_PARITY_EN
  ,
  output logic                  y_par
`endif
);
  localparam int SELW = $clog2(CH);
  localparam int CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   c_dwell_last = CW'(DWELL - 1);
  localparam logic [SELW-1:0] c_ptr_last   = SELW'(CH - 1);

  typedef enum logic [0:0] {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } state_t;

  state_t          r_state;
  logic [SELW-1:0] r_ptr;
  logic [SELW-1:0] r_ch;
  logic [CW-1:0]   r_dwell;
  logic [W-1:0]    r_y;
  logic            r_valid;
  logic            r_wrap;

  logic [W-1:0]    w_ch [CH];
  logic            w_scan_step;
  logic            w_dwell_done;
  logic [SELW-1:0] w_ptr_inc;
  logic [SELW-1:0] w_out_ch;
  logic [W-1:0]    w_y_nxt;

  for (genvar k = 0; k < CH; k++) begin : g_unpack
    assign w_ch[k] = din[k*W +: W];
  end

  // The entry edge counts as dwell cycle 0, so a continuing scan outputs the
  // post-advance pointer: each channel is shown for exactly DWELL cycles.
  always_comb begin
    w_scan_step  = (r_state == ST_SCAN) && mode;
    w_dwell_done = (r_dwell == c_dwell_last);
    w_ptr_inc    = r_ptr + SELW'(1);
    w_out_ch     = sel;
    if (w_scan_step) begin
      w_out_ch = w_dwell_done ? w_ptr_inc : r_ptr;
    end
    w_y_nxt = w_ch[w_out_ch];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_MANUAL;
      r_ptr   <= '0;
      r_dwell <= '0;
      r_ch    <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_valid <= en;
      r_wrap  <= 1'b0;
      if (en) begin
        r_y  <= w_y_nxt;
        r_ch <= w_out_ch;
        if (!mode) begin
          r_state <= ST_MANUAL;
        end else if (r_state == ST_MANUAL) begin
          r_state <= ST_SCAN;
          r_ptr   <= sel;
          r_dwell <= '0;
        end else if (w_dwell_done) begin
          r_dwell <= '0;
          r_ptr   <= w_ptr_inc;
          r_wrap  <= (r_ptr == c_ptr_last);
        end else begin
          r_dwell <= r_dwell + CW'(1);
        end
      end
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  logic r_y_par;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_par <= 1'b0;
    end else if (en) begin
      r_y_par <= ^w_y_nxt;
    end
  end

  assign y_par = r_y_par;
`endif

  assign y      = r_y;
  assign ch_out = r_ch;
  assign valid  = r_valid;
  assign wrap   = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_scan
// Desc     : Directed scoreboard bench for mux_scan (8x1 DWELL=4, 4x8 DWELL=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_scan;
  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       mode = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] din = '0;
  logic       y;
  logic [2:0] ch_out;
  logic       valid;
  logic       wrap;

  logic [31:0] din2 = 32'hD4C3B2A1;
  logic [1:0]  sel2 = '0;
  logic        mode2 = 1'b0;
  logic [7:0]  y2;
  logic [1:0]  ch2;
  logic        valid2;
  logic        wrap2;
`ifdef MUX_SCAN_PARITY_EN
  logic        y_par;
  logic        y_par2;
`endif

  always #5 clk = ~clk;

  mux_scan #(.CH(8), .W(1), .DWELL(DWELL)) u_dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .en(en),
    .y(y), .ch_out(ch_out), .valid(valid), .wrap(wrap)
`ifdef MUX_SCAN_PARITY_EN
    , .y_par(y_par)
`endif
  );

  mux_scan #(.CH(4), .W(8), .DWELL(1)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2), .sel(sel2), .mode(mode2), .en(1'b1),
    .y(y2), .ch_out(ch2), .valid(valid2), .wrap(wrap2)
`ifdef MUX_SCAN_PARITY_EN
    , .y_par(y_par2)
`endif
  );

  typedef struct {
    logic       y;
    logic [2:0] ch;
    logic       v;
    logic       w;
  } exp_t;

  typedef struct {
    logic [7:0] y;
    logic [1:0] ch;
    logic       w;
  } exp2_t;

  exp_t  q[$];
  exp2_t q2[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model: tracks remaining cycles on the current channel.
  bit m_scan = 0;
  int m_ptr = 0;
  int m_left = 0;
  int m_ch = 0;
  logic m_y = 1'b0;

  task automatic cmp(input string tag, input string what,
                     input logic [31:0] got, input logic [31:0] expv);
    vectors++;
    assert (got === expv) else begin
      miscompares++;
      $error("FAIL %s.%s got=%0h expected=%0h", tag, what, got, expv);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    e.w = 1'b0;
    if (rst) begin
      m_scan = 0; m_ptr = 0; m_left = 0; m_ch = 0; m_y = 1'b0;
      e.v = 1'b0;
    end else begin
      e.v = en;
      if (en) begin
        if (!mode) begin
          m_scan = 0;
          m_ch   = int'(sel);
        end else if (!m_scan) begin
          m_scan = 1;
          m_ptr  = int'(sel);
          m_left = DWELL - 1;
          m_ch   = m_ptr;
        end else if (m_left == 0) begin
          m_ptr  = (m_ptr + 1) % 8;
          m_left = DWELL - 1;
          e.w    = (m_ptr == 0);
          m_ch   = m_ptr;
        end else begin
          m_left--;
          m_ch = m_ptr;
        end
        m_y = din[m_ch];
      end
    end
    e.y  = m_y;
    e.ch = 3'(m_ch);
    q.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t  e;
    exp2_t e2;
    model_edge();
    @(posedge clk);
    #1;
    e = q.pop_front();
    cmp(tag, "y", 32'(y), 32'(e.y));
    cmp(tag, "ch_out", 32'(ch_out), 32'(e.ch));
    cmp(tag, "valid", 32'(valid), 32'(e.v));
    cmp(tag, "wrap", 32'(wrap), 32'(e.w));
`ifdef MUX_SCAN_PARITY_EN
    cmp(tag, "y_par", 32'(y_par), 32'(e.y));
`endif
    if (q2.size() > 0) begin
      e2 = q2.pop_front();
      cmp(tag, "y2", 32'(y2), 32'(e2.y));
      cmp(tag, "ch2", 32'(ch2), 32'(e2.ch));
      cmp(tag, "valid2", 32'(valid2), 32'd1);
      cmp(tag, "wrap2", 32'(wrap2), 32'(e2.w));
`ifdef MUX_SCAN_PARITY_EN
      cmp(tag, "y_par2", 32'(y_par2), 32'(^e2.y));
`endif
    end
  endtask

  task automatic push2(input logic [7:0] yv, input logic [1:0] cv, input logic wv);
    exp2_t e2;
    e2.y = yv; e2.ch = cv; e2.w = wv;
    q2.push_back(e2);
  endtask

  initial begin
    logic exp32 [8];
    exp32 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset, including with en low
    step("reset0");
    en = 1'b0;
    step("reset_en0");
    en = 1'b1;
    rst = 1'b0;

    // manual sweep
    din = 8'b1011_1101;
    for (int i = 0; i < 8; i++) begin
      sel = 3'(i);
      step("manual");
      cmp("manual_const", "y", 32'(y), 32'(exp32[i]));
    end

    // scan from channel 5 across the wrap; sel changes mid-scan are ignored
    din  = 8'b0110_0101;
    sel  = 3'd5;
    mode = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i == 6) sel = 3'd1;
      step("scan");
    end

    // freeze at ptr=3 dwell=2, then resume; din changes mid-dwell
    mode = 1'b0;
    step("to_manual");
    sel  = 3'd3;
    mode = 1'b1;
    step("entry3");
    step("dwell1");
    step("dwell2");
    en = 1'b0;
    for (int i = 0; i < 3; i++) step("frozen");
    en = 1'b1;
    step("resume");
    din = 8'b1111_0111;
    for (int i = 0; i < 4; i++) step("resume_adv");

    // reset with wrap imminent at ptr=7 dwell=3
    mode = 1'b0;
    step("to_manual2");
    sel  = 3'd7;
    mode = 1'b1;
    for (int i = 0; i < 4; i++) step("to_p7d3");
    rst = 1'b1;
    step("rst_midscan");
    rst  = 1'b0;
    mode = 1'b0;
    sel  = 3'd2;
    step("post_rst_manual");

    // mode 1 -> 0 mid-dwell, then re-entry at current sel
    din  = 8'b1010_0110;
    sel  = 3'd0;
    mode = 1'b1;
    for (int i = 0; i < 3; i++) step("scan0");
    mode = 1'b0;
    sel  = 3'd2;
    step("mid_dwell_exit");
    mode = 1'b1;
    sel  = 3'd6;
    for (int i = 0; i < 7; i++) step("reentry6");

    // 4x8 DWELL=1 scan from channel 0
    mode2 = 1'b1;
    push2(8'hA1, 2'd0, 1'b0);
    push2(8'hB2, 2'd1, 1'b0);
    push2(8'hC3, 2'd2, 1'b0);
    push2(8'hD4, 2'd3, 1'b0);
    push2(8'hA1, 2'd0, 1'b1);
    push2(8'hB2, 2'd1, 1'b0);
    for (int i = 0; i < 6; i++) step("dwell1_scan");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
